uart_to_tilelink_unpacker: RTL and testbench

Receives the host's 16-byte TileLink request packets as a byte stream from the STL UART client. Reassembles each packet and unpacks it into a TileLink frame for the GenericSerializer. It is the host-to-chip counterpart of the chip-to-host response packer and uses the same packet layout, which is a struct-packed `<BBBBLQ`:

- byte 0: chanId
- byte 1: {corrupt, param, unused, opcode}
- byte 2: size
- byte 3: union
- bytes 4–7: address, little-endian
- bytes 8–15: data, little-endian

---
 rtl/uart_to_tilelink_unpacker_if.sv | 36 +++
 rtl/uart_to_tilelink_unpacker.sv | 136 +++++++++++++
 tb/tb_uart_to_tilelink_unpacker.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_to_tilelink_unpacker_if.sv
// Byte-stream input from the UART client and TileLink frame output toward the
// GenericSerializer, grouped for the unpacker.
interface uart_to_tilelink_unpacker_if;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  rx_data;

  logic        tl_in_valid;
  logic        tl_in_ready;
  logic [2:0]  tl_in_bits_chanId;
  logic [2:0]  tl_in_bits_opcode;
  logic [2:0]  tl_in_bits_param;
  logic [7:0]  tl_in_bits_size;
  logic [7:0]  tl_in_bits_source;
  logic [63:0] tl_in_bits_address;
  logic [63:0] tl_in_bits_data;
  logic        tl_in_bits_corrupt;
  logic [8:0]  tl_in_bits_union;

  // master: the unpacker side
  modport master (
    input  rx_valid, rx_data, tl_in_ready,
    output rx_ready, tl_in_valid, tl_in_bits_chanId, tl_in_bits_opcode,
           tl_in_bits_param, tl_in_bits_size, tl_in_bits_source,
           tl_in_bits_address, tl_in_bits_data, tl_in_bits_corrupt,
           tl_in_bits_union
  );

  modport slave (
    output rx_valid, rx_data, tl_in_ready,
    input  rx_ready, tl_in_valid, tl_in_bits_chanId, tl_in_bits_opcode,
           tl_in_bits_param, tl_in_bits_size, tl_in_bits_source,
           tl_in_bits_address, tl_in_bits_data, tl_in_bits_corrupt,
           tl_in_bits_union
  );
endinterface

// File: rtl/uart_to_tilelink_unpacker.sv
// Reassembles 16-byte <BBBBLQ host request packets from the UART byte stream
// and presents each one as a TileLink frame; stale partial packets time out.
module uart_to_tilelink_unpacker #(
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int TIMEOUT_W      = 20
) (
  input  logic                          clk,
  input  logic                          reset_n,
  uart_to_tilelink_unpacker_if.master   bus,
  output logic                          err_timeout,
  output logic                          err_format,
  output logic [15:0]                   pkt_count
);

  localparam bit                 TO_EN     = (TIMEOUT_CYCLES != 0);
  localparam logic [TIMEOUT_W-1:0] IDLE_LAST =
    TIMEOUT_W'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic {COLLECT, ISSUE} state_t;

  typedef struct packed {
    logic [2:0]  chan;
    logic [2:0]  opcode;
    logic [2:0]  param;
    logic [7:0]  size;
    logic [63:0] addr;
    logic [63:0] data;
    logic        corrupt;
    logic [8:0]  uni;
  } frame_t;

  state_t               state, state_nxt;
  logic [3:0]           cnt;
  logic [TIMEOUT_W-1:0] idle;
  frame_t               frame;

  // Header byte 1 is kept without its ignored bit 3: {corrupt, param, opcode}.
  logic [7:0]  b0;
  logic [6:0]  b1;
  logic [7:0]  b2, b3;
  logic [31:0] addr_buf;
  logic [55:0] data_buf;

  logic accept, last, fmt_ok, timeout_hit;

  assign fmt_ok = (b0[7:3] == 5'd0);

  always_comb begin
    state_nxt    = state;
    bus.rx_ready = 1'b0;
    accept       = 1'b0;
    last         = 1'b0;
    timeout_hit  = 1'b0;
    case (state)
      COLLECT: begin
        bus.rx_ready = 1'b1;
        accept       = bus.rx_valid;
        last         = accept && (cnt == 4'd15);
        if (last && fmt_ok) state_nxt = ISSUE;
        // an accepted byte on the expiry edge wins over the timeout
        timeout_hit  = TO_EN && !accept && (cnt != 4'd0) && (idle == IDLE_LAST);
      end
      ISSUE: begin
        if (bus.tl_in_ready) state_nxt = COLLECT;
      end
      default: state_nxt = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= COLLECT;
      cnt         <= '0;
      idle        <= '0;
      frame       <= '0;
      b0          <= '0;
      b1          <= '0;
      b2          <= '0;
      b3          <= '0;
      addr_buf    <= '0;
      data_buf    <= '0;
      err_timeout <= 1'b0;
      err_format  <= 1'b0;
      pkt_count   <= '0;
    end else begin
      state       <= state_nxt;
      err_timeout <= timeout_hit;
      err_format  <= last && !fmt_ok;

      if (accept) begin
        cnt <= cnt + 4'd1;
        case (cnt)
          4'd0:                      b0 <= bus.rx_data;
          4'd1:                      b1 <= {bus.rx_data[7:4], bus.rx_data[2:0]};
          4'd2:                      b2 <= bus.rx_data;
          4'd3:                      b3 <= bus.rx_data;
          4'd4, 4'd5, 4'd6, 4'd7:    addr_buf[{cnt[1:0], 3'b000} +: 8] <= bus.rx_data;
          4'd8, 4'd9, 4'd10, 4'd11,
          4'd12, 4'd13, 4'd14:       data_buf[{cnt[2:0], 3'b000} +: 8] <= bus.rx_data;
          default: ;
        endcase
      end else if (timeout_hit) begin
        cnt <= '0;
      end

      if (accept || timeout_hit || cnt == 4'd0) idle <= '0;
      else if (TO_EN && state == COLLECT)       idle <= idle + 1'b1;

      // byte 15 goes straight into the frame alongside the buffered bytes
      if (last && fmt_ok) begin
        frame.chan    <= b0[2:0];
        frame.opcode  <= b1[2:0];
        frame.param   <= b1[5:3];
        frame.corrupt <= b1[6];
        frame.size    <= b2;
        frame.uni     <= {1'b0, b3};
        frame.addr    <= {32'h0, addr_buf};
        frame.data    <= {bus.rx_data, data_buf};
      end

      if (state == ISSUE && bus.tl_in_ready) pkt_count <= pkt_count + 16'd1;
    end
  end

  assign bus.tl_in_valid        = (state == ISSUE);
  assign bus.tl_in_bits_chanId  = frame.chan;
  assign bus.tl_in_bits_opcode  = frame.opcode;
  assign bus.tl_in_bits_param   = frame.param;
  assign bus.tl_in_bits_size    = frame.size;
  assign bus.tl_in_bits_source  = 8'h00;
  assign bus.tl_in_bits_address = frame.addr;
  assign bus.tl_in_bits_data    = frame.data;
  assign bus.tl_in_bits_corrupt = frame.corrupt;
  assign bus.tl_in_bits_union   = frame.uni;

endmodule

// File: tb/tb_uart_to_tilelink_unpacker.sv
// Scoreboard bench: stimulus pushes expected frames computed from the packet
// layout; a negedge monitor checks every presented frame and error pulse.
module tb_uart_to_tilelink_unpacker;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  uart_to_tilelink_unpacker_if bus();
  logic        err_timeout, err_format;
  logic [15:0] pkt_count;

  uart_to_tilelink_unpacker #(.TIMEOUT_CYCLES(8), .TIMEOUT_W(20)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus),
    .err_timeout(err_timeout), .err_format(err_format), .pkt_count(pkt_count)
  );

  typedef struct {
    logic [2:0]  chan, opcode, param;
    logic [7:0]  size;
    logic [63:0] addr, data;
    logic        corrupt;
    logic [8:0]  uni;
  } exp_t;

  exp_t q[$];
  int total = 0, passed = 0;
  int n_done = 0, to_seen = 0, fmt_seen = 0, exp_to = 0, exp_fmt = 0;
  bit stall = 1'b0, rnd_rdy = 1'b0;
  byte unsigned pkt[16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Expected frame straight from the byte layout, using plain arithmetic.
  function automatic exp_t model();
    exp_t e;
    e.chan    = 3'(pkt[0] % 8);
    e.opcode  = 3'(pkt[1] % 8);
    e.param   = 3'((pkt[1] / 16) % 8);
    e.corrupt = (pkt[1] >= 128);
    e.size    = pkt[2];
    e.uni     = 9'(pkt[3]);
    e.addr    = 64'd0;
    e.data    = 64'd0;
    for (int i = 0; i < 4; i++) e.addr += 64'(pkt[4+i]) << (8*i);
    for (int i = 0; i < 8; i++) e.data += 64'(pkt[8+i]) << (8*i);
    return e;
  endfunction

  task automatic send_byte(input byte unsigned b);
    int g = 0;
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(negedge clk);
    while (!bus.rx_ready && g < 2000) begin @(negedge clk); g++; end
    if (!bus.rx_ready) chk("rx_ready_wait", 64'(bus.rx_ready), 64'd1);
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_pkt(input int maxgap);
    if ((pkt[0] / 8) != 0) exp_fmt++;
    else q.push_back(model());
    for (int i = 0; i < 16; i++) begin
      send_byte(pkt[i]);
      if (i < 15 && maxgap > 0) idle_cycles($urandom_range(0, maxgap));
    end
  endtask

  task automatic drain();
    int g = 0;
    while (q.size() != 0 && g < 500) begin @(posedge clk); #1; g++; end
    chk("drain", 64'(q.size()), 64'd0);
    idle_cycles(2);
  endtask

  task automatic load_ref();
    pkt = '{8'h00, 8'h04, 8'h03, 8'hFF, 8'h00, 8'h10, 8'h00, 8'h80,
            8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h78, 8'h56, 8'h34, 8'h12};
  endtask

  task automatic check_reset_vals();
    chk("rst_rx_ready", 64'(bus.rx_ready), 64'd1);
    chk("rst_valid", 64'(bus.tl_in_valid), 64'd0);
    chk("rst_address", bus.tl_in_bits_address, 64'd0);
    chk("rst_data", bus.tl_in_bits_data, 64'd0);
    chk("rst_hdr", 64'({bus.tl_in_bits_chanId, bus.tl_in_bits_opcode, bus.tl_in_bits_param,
                        bus.tl_in_bits_size, bus.tl_in_bits_corrupt, bus.tl_in_bits_union}), 64'd0);
    chk("rst_pkt_count", 64'(pkt_count), 64'd0);
    chk("rst_err", 64'({err_timeout, err_format}), 64'd0);
  endtask

  // tl_in_ready driver: stalled, random, or held high
  initial begin
    bus.tl_in_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      bus.tl_in_ready = stall ? 1'b0 : (rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      if (err_timeout) to_seen++;
      if (err_format)  fmt_seen++;
      if (bus.tl_in_valid) begin
        chk("rx_ready_in_issue", 64'(bus.rx_ready), 64'd0);
        if (q.size() == 0) chk("unexpected_frame", 64'd1, 64'd0);
        else begin
          chk("chanId",  64'(bus.tl_in_bits_chanId),  64'(q[0].chan));
          chk("opcode",  64'(bus.tl_in_bits_opcode),  64'(q[0].opcode));
          chk("param",   64'(bus.tl_in_bits_param),   64'(q[0].param));
          chk("size",    64'(bus.tl_in_bits_size),    64'(q[0].size));
          chk("source",  64'(bus.tl_in_bits_source),  64'd0);
          chk("address", bus.tl_in_bits_address,      q[0].addr);
          chk("data",    bus.tl_in_bits_data,         q[0].data);
          chk("corrupt", 64'(bus.tl_in_bits_corrupt), 64'(q[0].corrupt));
          chk("union",   64'(bus.tl_in_bits_union),   64'(q[0].uni));
          if (bus.tl_in_ready) begin
            chk("pkt_count", 64'(pkt_count), 64'(16'(n_done)));
            void'(q.pop_front());
            n_done++;
          end
        end
      end
    end
  end

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (2) @(posedge clk);
    bus.rx_valid = 1'b1;       // bytes offered during reset must be ignored
    bus.rx_data  = 8'h55;
    @(negedge clk);
    check_reset_vals();
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
    reset_n = 1'b1;
    idle_cycles(2);

    // reference packet, ready high
    load_ref();
    send_pkt(0);
    drain();

    // same packet under 10 cycles of backpressure with bytes on offer
    stall = 1'b1;
    send_pkt(0);
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'hAA;
    idle_cycles(10);
    bus.rx_valid = 1'b0;
    stall = 1'b0;
    drain();

    // 5 bytes then 8 idle cycles: partial packet dropped
    for (int i = 0; i < 5; i++) send_byte(8'(i + 1));
    idle_cycles(8);
    exp_to++;
    load_ref();
    pkt[2] = 8'h06;
    send_pkt(2);
    drain();

    // a 7-cycle stall mid-packet must not time out
    load_ref();
    pkt[0] = 8'h05;
    q.push_back(model());
    for (int i = 0; i < 16; i++) begin
      send_byte(pkt[i]);
      if (i == 2) idle_cycles(7);
    end
    drain();

    // format error then a good packet
    load_ref();
    pkt[0] = 8'h08;
    send_pkt(0);
    idle_cycles(3);
    load_ref();
    send_pkt(0);
    drain();

    // reset after 9 bytes
    for (int i = 0; i < 9; i++) send_byte(8'($urandom_range(0, 255)));
    reset_n = 1'b0;
    @(negedge clk);
    check_reset_vals();
    q.delete();
    n_done = 0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    load_ref();
    pkt[3] = 8'h21;
    send_pkt(0);
    drain();

    // two back-to-back packets, continuous valid
    load_ref();
    send_pkt(0);
    pkt[1] = 8'hF1;
    for (int i = 8; i < 16; i++) pkt[i] = 8'hFF;
    send_pkt(0);
    drain();

    // randomized packets with gaps, random ready, some format errors
    rnd_rdy = 1'b1;
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 16; i++) pkt[i] = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 4) == 0) pkt[0] = 8'(($urandom_range(1, 31) << 3) | $urandom_range(0, 7));
      else pkt[0] = 8'($urandom_range(0, 7));
      send_pkt(3);
      if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 6));
    end
    rnd_rdy = 1'b0;
    drain();
    idle_cycles(4);

    chk("timeout_pulses", 64'(to_seen), 64'(exp_to));
    chk("format_pulses", 64'(fmt_seen), 64'(exp_fmt));
    chk("final_pkt_count", 64'(pkt_count), 64'(16'(n_done)));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
